// File: rtl/dlx_mmio_pkg.sv
// Register map, STATUS bit positions and default window base for the DLX MMIO responder.
package dlx_mmio_pkg;

  localparam logic [31:0] MMIO_BASE_ADDR = 32'hFFFF_FF00;

  localparam logic [7:0] MMIO_CONSOLE = 8'h00;
  localparam logic [7:0] MMIO_STATUS  = 8'h04;
  localparam logic [7:0] MMIO_CYCLES  = 8'h08;
  localparam logic [7:0] MMIO_RELOAD  = 8'h0C;
  localparam logic [7:0] MMIO_TCOUNT  = 8'h10;
  localparam logic [7:0] MMIO_GPIO    = 8'h14;
  localparam logic [7:0] MMIO_LEVEL   = 8'h18;

  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVERFLOW = 2;
  localparam int STAT_EXPIRED  = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, no fall-through; a push into a full FIFO is accepted only when a pop
// frees the slot in the same cycle. The head reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dlx_mmio_responder.sv
// MMIO window beside sp_ram on the DLX data port: console FIFO, cycle counter, reload timer, GPIO.
// Reads are registered (1-cycle latency, rd_hit qualifies rd_data); the FIFO drains on tx_valid/tx_ready.
module dlx_mmio_responder
  import dlx_mmio_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = MMIO_BASE_ADDR,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_ena,
  input  logic                  wr_ena,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_hit,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  timer_irq,
  output logic [31:0]           gpio_out
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                  hit;
  logic [7:0]            reg_off;
  logic                  wr_en;
  logic                  rd_en;
  logic                  wr_console;
  logic                  wr_status;
  logic                  wr_cycles;
  logic                  wr_reload;
  logic                  wr_gpio;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  fifo_drop;
  logic [LW-1:0]         fifo_level;
  logic                  timer_fire;
  logic                  overflow;
  logic                  expired;
  logic [DATA_WIDTH-1:0] cycles;
  logic [DATA_WIDTH-1:0] reload;
  logic [DATA_WIDTH-1:0] tcount;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  unused_addr;

  assign hit         = (address[ADDR_WIDTH-1:8] == BASE_ADDR[ADDR_WIDTH-1:8]);
  assign reg_off     = {address[7:2], 2'b00};
  assign unused_addr = ^address[1:0];

  assign wr_en      = wr_ena && hit;
  assign rd_en      = rd_ena && hit;
  assign wr_console = wr_en && (reg_off == MMIO_CONSOLE);
  assign wr_status  = wr_en && (reg_off == MMIO_STATUS);
  assign wr_cycles  = wr_en && (reg_off == MMIO_CYCLES);
  assign wr_reload  = wr_en && (reg_off == MMIO_RELOAD);
  assign wr_gpio    = wr_en && (reg_off == MMIO_GPIO);

  assign tx_valid   = !fifo_empty;
  assign fifo_pop   = tx_valid && tx_ready;
  assign fifo_drop  = wr_console && fifo_full && !fifo_pop;
  assign timer_fire = !wr_reload && (reload != '0) && (tcount == '0);
  assign timer_irq  = expired;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_console),
    .push_data (wr_data[7:0]),
    .pop       (fifo_pop),
    .pop_data  (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst)            cycles <= '0;
    else if (wr_cycles) cycles <= wr_data;
    else                cycles <= cycles + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)          gpio_out <= '0;
    else if (wr_gpio) gpio_out <= wr_data[31:0];
  end

  // A RELOAD write takes priority over the countdown step in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      reload <= '0;
      tcount <= '0;
    end else if (wr_reload) begin
      reload <= wr_data;
      tcount <= wr_data;
    end else if (reload != '0) begin
      if (tcount == '0) tcount <= reload;
      else              tcount <= tcount - 1'b1;
    end
  end

  // Sticky bits: a same-cycle set beats the W1C clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      expired  <= 1'b0;
    end else begin
      if (fifo_drop)                               overflow <= 1'b1;
      else if (wr_status && wr_data[STAT_OVERFLOW]) overflow <= 1'b0;
      if (timer_fire)                              expired  <= 1'b1;
      else if (wr_status && wr_data[STAT_EXPIRED])  expired  <= 1'b0;
    end
  end

  always_comb begin
    rd_value = '0;
    case (reg_off)
      MMIO_STATUS: begin
        rd_value[STAT_EMPTY]    = fifo_empty;
        rd_value[STAT_FULL]     = fifo_full;
        rd_value[STAT_OVERFLOW] = overflow;
        rd_value[STAT_EXPIRED]  = expired;
      end
      MMIO_CYCLES: rd_value = cycles;
      MMIO_RELOAD: rd_value = reload;
      MMIO_TCOUNT: rd_value = tcount;
      MMIO_GPIO:   rd_value = gpio_out;
      MMIO_LEVEL:  rd_value = DATA_WIDTH'(fifo_level);
      default:     rd_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      rd_hit  <= 1'b0;
    end else begin
      rd_hit <= rd_en;
      if (rd_en) rd_data <= rd_value;
    end
  end

endmodule
